// File: rtl/sram_line_ctrl.sv
// sram_line_ctrl
// Bridges the data cache to a 256K x 16 asynchronous SRAM. A line fill is
// four 16-bit reads packed into a 64-bit line; a write-through is a 32-bit
// word split into two 16-bit writes (low half at the even address). Every
// SRAM access lasts WAIT_CYCLES clocks. Completion is a one-cycle sram_rdy.
// All SRAM-facing outputs come straight from flops, so nothing on the pads
// depends combinationally on the request inputs.
module sram_line_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sram_rd_en,
  input  logic        sram_wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [63:0] sram_rd_data,
  output logic        sram_rdy,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Wait-counter value of the final cycle of each access.
  localparam logic [3:0] LP_LAST   = 4'(WAIT_CYCLES - 1);
  // With one cycle per access the first cycle is also the last, so the write
  // strobe never drops.
  localparam logic       LP_SINGLE = 1'(WAIT_CYCLES == 1);

  state_t      r_state;
  logic [1:0]  r_beat;
  logic [3:0]  r_wait;
  logic [15:0] r_line;
  logic        r_word;
  logic [15:0] r_wdata_hi;
  logic [15:0] r_buf0;
  logic [15:0] r_buf1;
  logic [15:0] r_buf2;
  logic [63:0] r_rd_data;
  logic        r_rdy;
  logic [17:0] r_addr;
  logic        r_we_n;
  logic [15:0] r_dq_out;
  logic        r_oe;

  // Only addr[18:2] reaches the SRAM; the rest is byte offset or beyond 512 KB.
  logic        w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[31:19], addr[1:0]};

  assign sram_rd_data = r_rd_data;
  assign sram_rdy     = r_rdy;
  assign SRAM_ADDR    = r_addr;
  assign SRAM_WE_N    = r_we_n;
  assign SRAM_DQ_OUT  = r_dq_out;
  assign SRAM_DQ_OE   = r_oe;

  // Controller FSM: each edge computes the pad values for the coming cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_beat     <= 2'd0;
      r_wait     <= 4'd0;
      r_line     <= 16'd0;
      r_word     <= 1'b0;
      r_wdata_hi <= 16'd0;
      r_buf0     <= 16'd0;
      r_buf1     <= 16'd0;
      r_buf2     <= 16'd0;
      r_rd_data  <= 64'd0;
      r_rdy      <= 1'b0;
      r_addr     <= 18'd0;
      r_we_n     <= 1'b1;
      r_dq_out   <= 16'd0;
      r_oe       <= 1'b0;
    end else begin
      r_rdy  <= 1'b0;
      r_we_n <= 1'b1;
      r_oe   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sram_rd_en) begin
            r_state    <= S_READ;
            r_line     <= addr[18:3];
            r_word     <= addr[2];
            r_wdata_hi <= wr_data[31:16];
            r_beat     <= 2'd0;
            r_wait     <= 4'd0;
            r_addr     <= {addr[18:3], 2'b00};
          end else if (sram_wr_en) begin
            r_state    <= S_WRITE;
            r_line     <= addr[18:3];
            r_word     <= addr[2];
            r_wdata_hi <= wr_data[31:16];
            r_beat     <= 2'd0;
            r_wait     <= 4'd0;
            r_addr     <= {addr[18:2], 1'b0};
            r_dq_out   <= wr_data[15:0];
            r_oe       <= 1'b1;
            r_we_n     <= LP_SINGLE;
          end
        end
        S_READ: begin
          if (r_wait == LP_LAST) begin
            r_wait <= 4'd0;
            case (r_beat)
              2'd0:    r_buf0 <= SRAM_DQ_IN;
              2'd1:    r_buf1 <= SRAM_DQ_IN;
              2'd2:    r_buf2 <= SRAM_DQ_IN;
              default: r_rd_data <= {SRAM_DQ_IN, r_buf2, r_buf1, r_buf0};
            endcase
            if (r_beat == 2'd3) begin
              r_state <= S_DONE;
              r_rdy   <= 1'b1;
            end else begin
              r_addr <= {r_line, r_beat + 2'd1};
            end
            // Wraps 3 -> 0 as the line completes.
            r_beat <= r_beat + 2'd1;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_WRITE: begin
          r_oe <= 1'b1;
          if (r_wait == LP_LAST) begin
            r_wait <= 4'd0;
            if (r_beat[0]) begin
              r_state <= S_DONE;
              r_rdy   <= 1'b1;
              r_oe    <= 1'b0;
              r_beat  <= 2'd0;
            end else begin
              r_beat   <= 2'd1;
              r_addr   <= {r_line, r_word, 1'b1};
              r_dq_out <= r_wdata_hi;
              r_we_n   <= LP_SINGLE;
            end
          end else begin
            r_wait <= r_wait + 4'd1;
            // Strobe rises for the final cycle so address and data are held
            // across the SRAM's write-end edge.
            r_we_n <= ((r_wait + 4'd1) == LP_LAST);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Bench for sram_line_ctrl: three instances (WAIT_CYCLES 2, 1, 15), each on
// its own behavioural SRAM. Expected lines, write lists and latencies come
// from the transaction-level rules, not from the controller's internals.
module tb_sram_line_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rd_en  [3];
  logic        wr_en  [3];
  logic [31:0] a_in   [3];
  logic [31:0] d_in   [3];
  logic [63:0] rdata  [3];
  logic        rdy    [3];
  logic [17:0] saddr  [3];
  logic        we_n   [3];
  logic [15:0] dq_out [3];
  logic        oe     [3];
  logic [15:0] dq_in  [3];

  logic [15:0] mem [3][262144];

  assign dq_in[0] = mem[0][saddr[0]];
  assign dq_in[1] = mem[1][saddr[1]];
  assign dq_in[2] = mem[2][saddr[2]];

  sram_line_ctrl #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .sram_rd_en(rd_en[0]), .sram_wr_en(wr_en[0]),
    .addr(a_in[0]), .wr_data(d_in[0]), .sram_rd_data(rdata[0]), .sram_rdy(rdy[0]),
    .SRAM_ADDR(saddr[0]), .SRAM_WE_N(we_n[0]), .SRAM_DQ_OUT(dq_out[0]),
    .SRAM_DQ_OE(oe[0]), .SRAM_DQ_IN(dq_in[0]));

  sram_line_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .sram_rd_en(rd_en[1]), .sram_wr_en(wr_en[1]),
    .addr(a_in[1]), .wr_data(d_in[1]), .sram_rd_data(rdata[1]), .sram_rdy(rdy[1]),
    .SRAM_ADDR(saddr[1]), .SRAM_WE_N(we_n[1]), .SRAM_DQ_OUT(dq_out[1]),
    .SRAM_DQ_OE(oe[1]), .SRAM_DQ_IN(dq_in[1]));

  sram_line_ctrl #(.WAIT_CYCLES(15)) u_dut2 (
    .clk(clk), .rst(rst), .sram_rd_en(rd_en[2]), .sram_wr_en(wr_en[2]),
    .addr(a_in[2]), .wr_data(d_in[2]), .sram_rd_data(rdata[2]), .sram_rdy(rdy[2]),
    .SRAM_ADDR(saddr[2]), .SRAM_WE_N(we_n[2]), .SRAM_DQ_OUT(dq_out[2]),
    .SRAM_DQ_OE(oe[2]), .SRAM_DQ_IN(dq_in[2]));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          inst;
    logic [17:0] a;
    logic [15:0] d;
    int          lo;
  } wrec_t;

  wrec_t       wq [$];
  int          wcnt    [3];
  logic [17:0] waddr   [3];
  logic [15:0] wdat    [3];
  logic        prev_rdy[3];
  logic [63:0] exp_rd  [3];
  logic [63:0] obs_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wv(input int i);
    if (i == 0) return 2;
    else if (i == 1) return 1;
    else return 15;
  endfunction

  function automatic logic [15:0] hash(input int i, input int a);
    return 16'((a ^ ((a >> 5) * 40503)) + i * 4369);
  endfunction

  function automatic logic [63:0] line_of(input int i, input logic [31:0] a);
    logic [17:0] base;
    base = {a[18:3], 2'b00};
    return {mem[i][base + 18'd3], mem[i][base + 18'd2], mem[i][base + 18'd1], mem[i][base]};
  endfunction

  // SRAM model: commits on every strobe-low cycle, logs one record per write pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        wcnt[i] = 0;
      end else if (!we_n[i]) begin
        chk("we_needs_oe", oe[i], 1);
        mem[i][saddr[i]] = dq_out[i];
        wcnt[i]++;
        waddr[i] = saddr[i];
        wdat[i]  = dq_out[i];
      end else if (wcnt[i] > 0) begin
        wrec_t r;
        chk("wr_hold_addr", saddr[i], waddr[i]);
        chk("wr_hold_data", dq_out[i], wdat[i]);
        r.inst = i; r.a = waddr[i]; r.d = wdat[i]; r.lo = wcnt[i];
        wq.push_back(r);
        wcnt[i] = 0;
      end
      if (rdy[i]) chk("rdy_single", prev_rdy[i], 0);
      prev_rdy[i] = rdy[i];
    end
  end

  task automatic check_writes(input int i, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = wv(i);
    if (w > 1) begin
      chk("wr_count", wq.size(), 2);
      if (wq.size() == 2) begin
        chk("wr0_inst", wq[0].inst, i);
        chk("wr0_addr", wq[0].a, {a[18:2], 1'b0});
        chk("wr0_data", wq[0].d, d[15:0]);
        chk("wr0_we_cycles", wq[0].lo, w - 1);
        chk("wr1_addr", wq[1].a, {a[18:2], 1'b1});
        chk("wr1_data", wq[1].d, d[31:16]);
        chk("wr1_we_cycles", wq[1].lo, w - 1);
      end
    end else begin
      chk("wr_count_single", wq.size(), 0);
    end
  endtask

  // One request held until its completion pulse; called on a falling edge with the DUT idle.
  task automatic run_txn(input int i, input bit rd, input logic [31:0] a, input logic [31:0] d);
    int          w, lat, acc;
    bit          seen;
    logic [63:0] exp_line;
    w        = wv(i);
    exp_line = rd ? line_of(i, a) : exp_rd[i];
    lat      = rd ? 4 * w + 1 : 2 * w + 1;
    wq.delete();
    acc      = cyc;
    rd_en[i] = rd;
    wr_en[i] = !rd;
    a_in[i]  = a;
    d_in[i]  = d;
    seen     = 1'b0;
    for (int n = 0; n < lat + 8 && !seen; n++) begin
      @(negedge clk);
      if (rdy[i]) seen = 1'b1;
    end
    rd_en[i] = 1'b0;
    wr_en[i] = 1'b0;
    if (!seen) begin
      chk("rdy_timeout", 0, 1);
    end else begin
      chk(rd ? "rd_latency" : "wr_latency", cyc - acc, lat);
      chk(rd ? "rd_data" : "rd_data_after_wr", rdata[i], exp_line);
      obs_rd    = rdata[i];
      exp_rd[i] = exp_line;
      if (rd) chk("rd_no_write", wq.size(), 0);
      else    check_writes(i, a, d);
    end
    @(negedge clk);
    chk("rdy_drop", rdy[i], 0);
  endtask

  // Read and write raised together: read first, write accepted right after.
  task automatic run_both(input int i, input logic [31:0] a, input logic [31:0] d);
    int          w, acc, acc2;
    bit          seen;
    logic [63:0] exp_line;
    w        = wv(i);
    exp_line = line_of(i, a);
    wq.delete();
    acc      = cyc;
    rd_en[i] = 1'b1;
    wr_en[i] = 1'b1;
    a_in[i]  = a;
    d_in[i]  = d;
    seen     = 1'b0;
    for (int n = 0; n < 4 * w + 9 && !seen; n++) begin
      @(negedge clk);
      if (rdy[i]) seen = 1'b1;
    end
    if (!seen) begin
      chk("both_rd_timeout", 0, 1);
    end else begin
      chk("both_rd_latency", cyc - acc, 4 * w + 1);
      chk("both_rd_data", rdata[i], exp_line);
      chk("both_no_we_in_rd", wq.size() + wcnt[i], 0);
      exp_rd[i] = exp_line;
    end
    rd_en[i] = 1'b0;
    acc2     = cyc + 1;
    seen     = 1'b0;
    for (int n = 0; n < 2 * w + 9 && !seen; n++) begin
      @(negedge clk);
      if (rdy[i]) seen = 1'b1;
    end
    wr_en[i] = 1'b0;
    if (!seen) begin
      chk("both_wr_timeout", 0, 1);
    end else begin
      chk("both_wr_latency", cyc - acc2, 2 * w + 1);
      chk("both_rd_data_kept", rdata[i], exp_rd[i]);
      check_writes(i, a, d);
    end
    @(negedge clk);
    chk("both_rdy_drop", rdy[i], 0);
  endtask

  task automatic reset_mid_write();
    logic [31:0] a, d;
    logic [15:0] before1;
    bit          rdy_seen;
    a       = 32'h0000_0130;
    d       = 32'hCAFE_F00D;
    before1 = mem[0][{a[18:2], 1'b1}];
    wq.delete();
    wr_en[0] = 1'b1;
    a_in[0]  = a;
    d_in[0]  = d;
    @(posedge clk);
    #2;
    chk("mw_we_low", we_n[0], 0);
    chk("mw_oe_high", oe[0], 1);
    rst = 1'b0;
    #1;
    chk("mw_we_released", we_n[0], 1);
    chk("mw_oe_released", oe[0], 0);
    chk("mw_rdy_low", rdy[0], 0);
    @(negedge clk);
    wr_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) exp_rd[i] = 64'd0;
    rdy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rdy[0]) rdy_seen = 1'b1;
    end
    chk("mw_no_rdy", rdy_seen, 0);
    chk("mw_no_write", wq.size(), 0);
    chk("mw_beat1_mem", mem[0][{a[18:2], 1'b1}], before1);
    chk("mw_rd_data_cleared", rdata[0], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 262144; a++) mem[i][a] = hash(i, a);
      rd_en[i] = 1'b0; wr_en[i] = 1'b0; a_in[i] = 32'd0; d_in[i] = 32'd0;
      wcnt[i] = 0; prev_rdy[i] = 1'b0; exp_rd[i] = 64'd0;
    end
    rst      = 1'b0;
    rd_en[0] = 1'b1;
    a_in[0]  = 32'h0000_1230;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rdy", rdy[0], 0);
      chk("rst_we_n", we_n[0], 1);
      chk("rst_oe", oe[0], 0);
    end
    chk("rst_addr", saddr[0], 0);
    chk("rst_rd_data", rdata[0], 0);
    chk("rst_dq_out", dq_out[0], 0);
    rst = 1'b1;
    run_txn(0, 1'b1, 32'h0000_1230, 32'd0);

    mem[0][18'h204] = 16'h1111;
    mem[0][18'h205] = 16'h2222;
    mem[0][18'h206] = 16'h3333;
    mem[0][18'h207] = 16'h4444;
    run_txn(0, 1'b1, 32'h0000_0408, 32'd0);
    chk("line_const", obs_rd, 64'h4444_3333_2222_1111);

    run_txn(0, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF);
    chk("mem_00A", mem[0][18'h00A], 16'hBEEF);
    chk("mem_00B", mem[0][18'h00B], 16'hDEAD);

    run_both(0, 32'h0000_0A6C, 32'h1234_5678);

    reset_mid_write();

    run_txn(1, 1'b1, 32'h0000_0000, 32'd0);
    run_txn(1, 1'b1, 32'h0007_FFF8, 32'd0);
    run_txn(2, 1'b1, 32'h0000_0000, 32'd0);
    run_txn(2, 1'b1, 32'h0007_FFF8, 32'd0);
    chk("top_line_w15", obs_rd,
        {hash(2, 32'h3FFFF), hash(2, 32'h3FFFE), hash(2, 32'h3FFFD), hash(2, 32'h3FFFC)});

    for (int k = 0; k < 40; k++) begin
      int          sel, i;
      bit          rd;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      i   = (sel < 6) ? 0 : ((sel < 8) ? 1 : 2);
      rd  = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      a   = $urandom;
      d   = $urandom;
      if (i == 0 && $urandom_range(0, 4) == 0) run_both(0, a, d);
      else run_txn(i, rd, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_line_ctrl.md
# sram_line_ctrl

Memory-side controller directly downstream of the two-way data cache. It accepts the cache's miss-fill read and write-through requests and drives a 256K x 16 asynchronous SRAM with a fixed number of wait cycles per access. It assembles four 16-bit reads into one 64-bit cache line and splits each 32-bit write into two 16-bit writes. Completion is reported with a one-cycle ready pulse that the cache and pipeline use as their stall release.

## Interface
- WAIT_CYCLES, 2, clock cycles per 16-bit SRAM access; legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sram_rd_en  in  1  line-fill request from the cache; held high until `sram_rdy`.
- sram_wr_en  in  1  word write request; held high until `sram_rdy`.
- addr  in  32  byte address. Bits [18:3] select the line; bit [2] selects the word.
- wr_data  in  32  write data.
- sram_rd_data  out  64  assembled line. 16-bit beat k occupies bits [16k+15:16k].
- sram_rdy  out  1  one-cycle completion pulse.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  SRAM write enable, active-low.
- SRAM_DQ_OUT  out  16  write data driven to the SRAM.
- SRAM_DQ_OE  out  1  high to drive SRAM_DQ_OUT onto the pad; top level builds the tristate.
- SRAM_DQ_IN  in  16  read data from the pad.

## Operation
- States:
  - IDLE: waits for a request.
  - READ: performs 4 beats.
  - WRITE: performs 2 beats.
  - DONE: pulses `sram_rdy` for one cycle.
- IDLE transitions:
  - `sram_rd_en`=1 → READ. Read has priority if both enables are high.
  - else `sram_wr_en`=1 → WRITE.
  - In both cases `addr[18:2]` and `wr_data` are latched, and the beat and wait counters are cleared.
  - Request inputs are ignored outside IDLE.
- READ, beat k (0..3):
  - SRAM_ADDR = {line, k[1:0]}, WE_N=1, OE=0.
  - On the last wait cycle (wait counter = WAIT_CYCLES-1), SRAM_DQ_IN is captured into line-buffer slot k, the wait counter is cleared, and the beat advances.
  - After beat 3 → DONE.
- WRITE, beat k (0..1):
  - SRAM_ADDR = {line, word, k[0]}, OE=1.
  - SRAM_DQ_OUT = wr_data[16k+15:16k], so the low half goes to the even address.
  - WE_N=0 on every cycle of the beat except its last, where WE_N=1 with address and data still held.
  - After beat 1 → DONE.
- DONE:
  - `sram_rdy`=1. `sram_rd_data` is the line buffer after a read; it is unchanged after a write.
  - Next state is IDLE unconditionally.
- `sram_rd_data` holds its value until the next read's DONE. Buffer slots update only on capture.
- Counters are 2-bit (beat) and 4-bit (wait). The beat counter wraps to 0 on entering DONE.
- Idle outputs: SRAM_ADDR holds its last value, WE_N=1, OE=0.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE, `sram_rdy`=0, `sram_rd_data`=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ_OUT=0, SRAM_DQ_OE=0, all counters 0.
  - This takes effect immediately, including mid-transaction. An aborted transaction never raises `sram_rdy`, and the write strobe is released without waiting for a clock edge.
- Read latency: accepting edge E, then `sram_rdy` is high during cycle E+4·WAIT_CYCLES+1. With the default, that is 9 cycles after acceptance.
- Write latency: `sram_rdy` is high during cycle E+2·WAIT_CYCLES+1.
- `sram_rdy` is high for exactly one cycle per accepted request and is never asserted in consecutive cycles.
- A request still high in the cycle after DONE is treated as a new request and accepted at that edge.
- Outputs are registered or decoded from the state and counters only. No combinational path exists from request inputs to any output.

## Test plan
- Reset with request active:
  - Stimulus: rst low for 3 cycles while `sram_rd_en`=1.
  - Required: all outputs at their reset values, no SRAM activity, `sram_rdy`=0.
  - After rst rises, the read starts at the next edge.
- Line read:
  - Stimulus: `addr`=0x0000_0408, SRAM model returns 0x1111/0x2222/0x3333/0x4444 at halfword addresses 0x204..0x207.
  - Required: `sram_rdy` pulses 9 cycles after acceptance with `sram_rd_data`=0x4444_3333_2222_1111.
- Word write:
  - Stimulus: `addr`=0x0000_0014, `wr_data`=0xDEAD_BEEF.
  - Required: 0xBEEF is written at 0x00A and 0xDEAD at 0x00B, each with WE_N low for exactly 1 cycle.
  - `sram_rdy` pulses 5 cycles after acceptance; `sram_rd_data` is unchanged.
- Simultaneous requests:
  - Stimulus: `sram_rd_en`=`sram_wr_en`=1.
  - Required: the read is serviced first, WE_N stays high throughout, then the write is serviced.
  - Each completion gets its own single-cycle `sram_rdy`.
- Reset mid-write:
  - Stimulus: rst asserted during beat 0 of a write, while WE_N=0.
  - Required: WE_N=1 and OE=0 within the same cycle, no `sram_rdy`, and the SRAM model shows no write at beat 1.
- Parameter sweep:
  - Stimulus: WAIT_CYCLES=1 and WAIT_CYCLES=15, back-to-back reads at addresses 0x0 and 0x7_FFF8.
  - Required: latencies are 5 and 61 cycles respectively.
  - The top line gives SRAM_ADDR 0x3FFFC..0x3FFFF with no address wrap error.
